// File: rtl/reg_cmd_ctrl.sv
// Framed UART command front-end: parses write/read frames and drives register-file strobes.
// Build option: define REG_CMD_WR_ACK_EN to echo every written byte back over UART TX.
module reg_cmd_ctrl #(
    parameter int unsigned reg_num     = 16,
    parameter int unsigned reg_width   = 8,
    parameter int unsigned ADDR_SIZE   = 4,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                 CLK,
    input  logic                 rst_n,
    input  logic [reg_width-1:0] RX_P_DATA,
    input  logic                 RX_D_VLD,
    input  logic [reg_width-1:0] Rd_Data,
    input  logic                 Rd_Data_VLD,
    input  logic                 TX_Busy,
    output logic                 WrEN,
    output logic                 RdEN,
    output logic [ADDR_SIZE-1:0] Address,
    output logic [reg_width-1:0] WrData,
    output logic [reg_width-1:0] TX_P_DATA,
    output logic                 TX_D_VLD,
    output logic                 Cmd_Err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [reg_width-1:0] CMD_WR = reg_width'(8'hAA);
    localparam logic [reg_width-1:0] CMD_RD = reg_width'(8'hBB);

    typedef enum logic [2:0] {
        IDLE, WR_ADDR, WR_DATA, WR_EXEC, RD_ADDR, RD_EXEC, RD_WAIT, TX_SEND
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ADDR_SIZE-1:0] addr_q, addr_d;
    logic [reg_width-1:0] wdata_q, wdata_d;
    logic [reg_width-1:0] tx_buf_q, tx_buf_d;
    logic                 wr_en_q, wr_en_d;
    logic                 rd_en_q, rd_en_d;
    logic                 tx_vld_q, tx_vld_d;
    logic                 err_q, err_d;
    logic                 tout_c;
    logic                 addr_bad_c;

    assign tout_c     = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    assign addr_bad_c = (32'(RX_P_DATA) >= reg_num);

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        state_d  = state_q;
        cnt_d    = '0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        tx_buf_d = tx_buf_q;
        wr_en_d  = 1'b0;
        rd_en_d  = 1'b0;
        tx_vld_d = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (RX_D_VLD) begin
                    if (RX_P_DATA == CMD_WR) begin
                        state_d = WR_ADDR;
                    end else if (RX_P_DATA == CMD_RD) begin
                        state_d = RD_ADDR;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            WR_ADDR, RD_ADDR: begin
                if (RX_D_VLD) begin
                    if (addr_bad_c) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        addr_d  = ADDR_SIZE'(RX_P_DATA);
                        rd_en_d = (state_q == RD_ADDR);
                        state_d = (state_q == WR_ADDR) ? WR_DATA : RD_EXEC;
                    end
                end else if (tout_c) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WR_DATA: begin
                if (RX_D_VLD) begin
                    wdata_d = RX_P_DATA;
`ifdef REG_CMD_WR_ACK_EN
                    tx_buf_d = RX_P_DATA;
`endif
                    wr_en_d = 1'b1;
                    state_d = WR_EXEC;
                end else if (tout_c) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WR_EXEC: begin
                err_d = RX_D_VLD;
`ifdef REG_CMD_WR_ACK_EN
                state_d = TX_SEND;
`else
                state_d = IDLE;
`endif
            end
            RD_EXEC: begin
                err_d   = RX_D_VLD;
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                // A stray byte is flagged but still restarts the watchdog.
                err_d = RX_D_VLD;
                if (Rd_Data_VLD) begin
                    tx_buf_d = Rd_Data;
                    if (!TX_Busy) begin
                        tx_vld_d = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        state_d = TX_SEND;
                    end
                end else if (!RX_D_VLD) begin
                    if (tout_c) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            TX_SEND: begin
                err_d = RX_D_VLD;
                if (!TX_Busy) begin
                    tx_vld_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            tx_buf_q <= '0;
            wr_en_q  <= 1'b0;
            rd_en_q  <= 1'b0;
            tx_vld_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            tx_buf_q <= tx_buf_d;
            wr_en_q  <= wr_en_d;
            rd_en_q  <= rd_en_d;
            tx_vld_q <= tx_vld_d;
            err_q    <= err_d;
        end
    end

    assign WrEN      = wr_en_q;
    assign RdEN      = rd_en_q;
    assign Address   = addr_q;
    assign WrData    = wdata_q;
    assign TX_P_DATA = tx_buf_q;
    assign TX_D_VLD  = tx_vld_q;
    assign Cmd_Err   = err_q;

endmodule

// File: tb/tb_reg_cmd_ctrl.sv
// Self-checking bench for reg_cmd_ctrl: frame vector table plus corner sequences, scoreboarded events.
module tb_reg_cmd_ctrl;

    localparam int unsigned REG_W  = 8;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned TOUT   = 1024;

    logic              CLK = 1'b0;
    logic              rst_n;
    logic [REG_W-1:0]  RX_P_DATA;
    logic              RX_D_VLD;
    logic [REG_W-1:0]  Rd_Data;
    logic              Rd_Data_VLD;
    logic              TX_Busy;
    logic              WrEN;
    logic              RdEN;
    logic [ADDR_W-1:0] Address;
    logic [REG_W-1:0]  WrData;
    logic [REG_W-1:0]  TX_P_DATA;
    logic              TX_D_VLD;
    logic              Cmd_Err;

    reg_cmd_ctrl #(
        .reg_num(16), .reg_width(REG_W), .ADDR_SIZE(ADDR_W), .TIMEOUT_CYC(TOUT)
    ) dut (
        .CLK(CLK), .rst_n(rst_n), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .Rd_Data(Rd_Data), .Rd_Data_VLD(Rd_Data_VLD), .TX_Busy(TX_Busy),
        .WrEN(WrEN), .RdEN(RdEN), .Address(Address), .WrData(WrData),
        .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .Cmd_Err(Cmd_Err)
    );

    always #5 CLK = ~CLK;

    typedef enum int {EV_WR, EV_RD, EV_TX, EV_ERR} ev_e;
    typedef struct {
        ev_e               kind;
        int                cyc;
        logic [ADDR_W-1:0] addr;
        logic [REG_W-1:0]  data;
    } exp_t;

    typedef enum int {V_WR, V_RD, V_ERR} vk_e;
    typedef struct {
        int                nb;
        logic [2:0][7:0]   b;
        vk_e               kind;
        logic [ADDR_W-1:0] addr;
        logic [REG_W-1:0]  data;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    bit   rf_mute  = 1'b0;

    // Register-file model: answers a read one cycle after RdEN.
    logic [REG_W-1:0] mem [16];
    always @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            Rd_Data_VLD <= 1'b0;
            Rd_Data     <= '0;
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else begin
            Rd_Data_VLD <= RdEN && !rf_mute;
            if (RdEN) Rd_Data <= mem[Address];
            if (WrEN) mem[Address] <= WrData;
        end
    end

    function automatic void push(ev_e k, int c, logic [ADDR_W-1:0] a, logic [REG_W-1:0] d);
        exp_t e;
        e.kind = k; e.cyc = c; e.addr = a; e.data = d;
        sb.push_back(e);
    endfunction

    function automatic void check_ev(ev_e k, logic [ADDR_W-1:0] a, logic [REG_W-1:0] d);
        exp_t e;
        bit   bad;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event cyc=%0d got %s addr=%0h data=%0h, required no event",
                     cyc, k.name(), a, d);
            return;
        end
        e   = sb.pop_front();
        bad = (e.kind != k) || (e.cyc != cyc);
        if (k == EV_WR) bad = bad || (e.addr != a) || (e.data != d);
        if (k == EV_RD) bad = bad || (e.addr != a);
        if (k == EV_TX) bad = bad || (e.data != d);
        if (bad) begin
            failures++;
            $display("FAIL event got %s cyc=%0d addr=%0h data=%0h, required %s cyc=%0d addr=%0h data=%0h",
                     k.name(), cyc, a, d, e.kind.name(), e.cyc, e.addr, e.data);
        end
    endfunction

    // Output monitor, sampled 1 time unit after each rising edge.
    always @(posedge CLK) begin
        #1;
        cyc++;
        if (WrEN)     check_ev(EV_WR, Address, WrData);
        if (RdEN)     check_ev(EV_RD, Address, '0);
        if (TX_D_VLD) check_ev(EV_TX, '0, TX_P_DATA);
        if (Cmd_Err)  check_ev(EV_ERR, '0, '0);
    end

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic byte_on(input logic [7:0] b);
        @(negedge CLK);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
    endtask

    task automatic byte_off();
        @(negedge CLK);
        RX_D_VLD = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_on(b);
        byte_off();
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s: %0d expected events missing, first %s at cyc=%0d (now cyc=%0d)",
                     name, sb.size(), sb[0].kind.name(), sb[0].cyc, cyc);
            sb.delete();
        end
    endtask

    task automatic check_zero(input string name);
        checks++;
        if ({WrEN, RdEN, TX_D_VLD, Cmd_Err, Address, WrData, TX_P_DATA} != '0) begin
            failures++;
            $display("FAIL %s: outputs WrEN=%b RdEN=%b TXV=%b Err=%b Addr=%0h WrData=%0h TXD=%0h, required all 0",
                     name, WrEN, RdEN, TX_D_VLD, Cmd_Err, Address, WrData, TX_P_DATA);
        end
    endtask

    function automatic vec_t mk(int nb, logic [7:0] b0, logic [7:0] b1, logic [7:0] b2,
                                vk_e k, logic [ADDR_W-1:0] a, logic [REG_W-1:0] d);
        vec_t v;
        v.nb = nb; v.b[0] = b0; v.b[1] = b1; v.b[2] = b2;
        v.kind = k; v.addr = a; v.data = d;
        return v;
    endfunction

    function automatic void push_vec(vec_t v, int t0);
        case (v.kind)
            V_WR: begin
                push(EV_WR, t0, v.addr, v.data);
`ifdef REG_CMD_WR_ACK_EN
                push(EV_TX, t0 + 2, '0, v.data);
`endif
            end
            V_RD: begin
                push(EV_RD, t0, v.addr, '0);
                push(EV_TX, t0 + 2, '0, v.data);
            end
            default: push(EV_ERR, t0, '0, '0);
        endcase
    endfunction

    initial begin
        #(10 * 60000);
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   t0;
        rst_n     = 1'b0;
        RX_P_DATA = '0;
        RX_D_VLD  = 1'b0;
        TX_Busy   = 1'b0;

        vecs.push_back(mk(3, 8'hAA, 8'h01, 8'h5A, V_WR,  4'h1, 8'h5A));
        vecs.push_back(mk(3, 8'hAA, 8'h02, 8'h23, V_WR,  4'h2, 8'h23));
        vecs.push_back(mk(2, 8'hBB, 8'h02, 8'h00, V_RD,  4'h2, 8'h23));
        vecs.push_back(mk(3, 8'hAA, 8'h05, 8'h3C, V_WR,  4'h5, 8'h3C));
        vecs.push_back(mk(1, 8'h55, 8'h00, 8'h00, V_ERR, 4'h0, 8'h00));
        vecs.push_back(mk(2, 8'hAA, 8'h10, 8'h00, V_ERR, 4'h0, 8'h00));
        vecs.push_back(mk(2, 8'hBB, 8'h01, 8'h00, V_RD,  4'h1, 8'h5A));
        vecs.push_back(mk(3, 8'hAA, 8'h0F, 8'hC3, V_WR,  4'hF, 8'hC3));
        vecs.push_back(mk(2, 8'hBB, 8'h0F, 8'h00, V_RD,  4'hF, 8'hC3));
        vecs.push_back(mk(2, 8'hBB, 8'hFF, 8'h00, V_ERR, 4'h0, 8'h00));
        vecs.push_back(mk(1, 8'h00, 8'h00, 8'h00, V_ERR, 4'h0, 8'h00));
        vecs.push_back(mk(2, 8'hBB, 8'h05, 8'h00, V_RD,  4'h5, 8'h3C));
        vecs.push_back(mk(3, 8'hAA, 8'h00, 8'h81, V_WR,  4'h0, 8'h81));
        vecs.push_back(mk(2, 8'hBB, 8'h00, 8'h00, V_RD,  4'h0, 8'h81));

        idle(3);
        check_zero("reset_state");
        rst_n = 1'b1;
        idle(2);

        foreach (vecs[i]) begin
            v = vecs[i];
            for (int k = 0; k < v.nb; k++) begin
                byte_on(v.b[2'(k)]);
                if (k == v.nb - 1) push_vec(v, cyc + 1);
                byte_off();
            end
            idle(6);
            check_drained($sformatf("vec%0d", i));
        end

        // Read held off by TX_Busy for 50 cycles.
        TX_Busy = 1'b1;
        send_byte(8'hBB);
        byte_on(8'h05);
        push(EV_RD, cyc + 1, 4'h5, '0);
        byte_off();
        idle(50);
        TX_Busy = 1'b0;
        push(EV_TX, cyc + 1, '0, 8'h3C);
        idle(6);
        check_drained("tx_backpressure");

        // Byte arriving while a response waits in TX_SEND is dropped with an error.
        TX_Busy = 1'b1;
        send_byte(8'hBB);
        byte_on(8'h02);
        push(EV_RD, cyc + 1, 4'h2, '0);
        byte_off();
        idle(5);
        byte_on(8'h11);
        push(EV_ERR, cyc + 1, '0, '0);
        byte_off();
        idle(3);
        TX_Busy = 1'b0;
        push(EV_TX, cyc + 1, '0, 8'h23);
        idle(6);
        check_drained("stray_byte_tx_send");

        // Inter-byte timeout in WR_DATA, then a fresh write is accepted.
        send_byte(8'hAA);
        byte_on(8'h03);
        push(EV_ERR, cyc + 1 + TOUT, '0, '0);
        byte_off();
        idle(TOUT + 10);
        check_drained("wr_timeout");
        send_byte(8'hAA);
        send_byte(8'h06);
        byte_on(8'h77);
        t0 = cyc + 1;
        push(EV_WR, t0, 4'h6, 8'h77);
`ifdef REG_CMD_WR_ACK_EN
        push(EV_TX, t0 + 2, '0, 8'h77);
`endif
        byte_off();
        idle(6);
        check_drained("write_after_timeout");

        // Register file never answers: RD_WAIT times out.
        rf_mute = 1'b1;
        send_byte(8'hBB);
        byte_on(8'h04);
        t0 = cyc + 1;
        push(EV_RD, t0, 4'h4, '0);
        push(EV_ERR, t0 + 1 + TOUT, '0, '0);
        byte_off();
        idle(TOUT + 10);
        check_drained("rd_wait_timeout");
        rf_mute = 1'b0;

        // Reset in the middle of a write frame.
        send_byte(8'hAA);
        send_byte(8'h09);
        checks++;
        if (Address != 4'h9) begin
            failures++;
            $display("FAIL addr_latch: Address=%0h, required 9", Address);
        end
        @(negedge CLK);
        #2 rst_n = 1'b0;
        #1 check_zero("async_reset");
        idle(2);
        rst_n = 1'b1;
        byte_on(8'h07);
        push(EV_ERR, cyc + 1, '0, '0);
        byte_off();
        idle(6);
        check_drained("post_reset_cmd");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
